// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: VGA timing generator and frame-buffer reader.
// Generates 640x480-style timing, reads an IMG_W x IMG_H image from the frame buffer's
// synchronous read port, and presents an aligned pixel word with visible/sync/frame_start flags.
// Ports:
//   clk_i          pixel clock
//   rst_i          asynchronous active-high reset
//   fb_addr_o      registered frame-buffer read address
//   fb_rdata_i     frame-buffer read data, valid MEM_LATENCY cycles after fb_addr_o
//   pixel_out_o    {B,G,R} pixel word; 0 outside the active area
//   visible_o      high while pixel_out_o is in the active area
//   hsync_o        horizontal sync, active-low
//   vsync_o        vertical sync, active-low
//   frame_start_o  one-cycle pulse aligned with output pixel (0,0)
module vga_pixel_fetch #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned IMG_W       = 320,
  parameter int unsigned IMG_H       = 240,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [23:0] BG_COLOR    = 24'h000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] fb_addr_o,
  input  logic [23:0]       fb_rdata_i,
  output logic [23:0]       pixel_out_o,
  output logic              visible_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              frame_start_o
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);
  // Flag delay line is one stage shorter than the total latency; the output
  // register supplies the final stage.
  localparam int unsigned Depth  = MEM_LATENCY + 1;

  localparam logic [HW-1:0] HLast      = HW'(HTotal - 1);
  localparam logic [HW-1:0] HVis       = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HSyncStart = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HSyncEnd   = HW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [HW-1:0] ImgW       = HW'(IMG_W);
  localparam logic [VW-1:0] VLast      = VW'(VTotal - 1);
  localparam logic [VW-1:0] VVis       = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VSyncStart = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VSyncEnd   = VW'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [VW-1:0] ImgH       = VW'(IMG_H);

  // Flag word layout: {fs, vs, hs, img, vis}; idle has both syncs high.
  localparam logic [4:0] FlagsIdle = 5'b01100;

  logic [HW-1:0]           hc_q, hc_d;
  logic [VW-1:0]           vc_q, vc_d;
  logic [ADDR_W-1:0]       addr_cnt_q, addr_cnt_d;
  logic [ADDR_W-1:0]       fb_addr_q, fb_addr_d;
  logic [Depth-1:0][4:0]   flags_q, flags_d;
  logic [4:0]              flags0, flags_l;
  logic                    frame_wrap, img0;
  logic [23:0]             pixel_q, pixel_d;
  logic                    visible_q, hsync_q, vsync_q, frame_start_q;

  always_comb begin
    frame_wrap = (hc_q == HLast) && (vc_q == VLast);
    hc_d = (hc_q == HLast) ? '0 : hc_q + HW'(1);
    vc_d = vc_q;
    if (hc_q == HLast) begin
      vc_d = (vc_q == VLast) ? '0 : vc_q + VW'(1);
    end
  end

  always_comb begin
    img0      = (hc_q < ImgW) && (vc_q < ImgH);
    flags0[0] = (hc_q < HVis) && (vc_q < VVis);
    flags0[1] = img0;
    flags0[2] = !((hc_q >= HSyncStart) && (hc_q < HSyncEnd));
    flags0[3] = !((vc_q >= VSyncStart) && (vc_q < VSyncEnd));
    flags0[4] = (hc_q == '0) && (vc_q == '0);
  end

  // Row-major address counter: image pixels are contiguous in raster order, so a
  // running count replaces v*IMG_W+h.
  always_comb begin
    addr_cnt_d = addr_cnt_q;
    fb_addr_d  = fb_addr_q;
    if (img0) begin
      fb_addr_d  = addr_cnt_q;
      addr_cnt_d = addr_cnt_q + ADDR_W'(1);
    end
    if (frame_wrap) begin
      addr_cnt_d = '0;
    end
  end

  always_comb begin
    if (Depth > 1) begin
      flags_d = {flags_q[Depth-2:0], flags0};
    end else begin
      flags_d = flags0;
    end
    flags_l = flags_q[Depth-1];
    pixel_d = '0;
    if (flags_l[0]) begin
      pixel_d = flags_l[1] ? fb_rdata_i : BG_COLOR;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hc_q          <= '0;
      vc_q          <= '0;
      addr_cnt_q    <= '0;
      fb_addr_q     <= '0;
      flags_q       <= {Depth{FlagsIdle}};
      pixel_q       <= '0;
      visible_q     <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      addr_cnt_q    <= addr_cnt_d;
      fb_addr_q     <= fb_addr_d;
      flags_q       <= flags_d;
      pixel_q       <= pixel_d;
      visible_q     <= flags_l[0];
      hsync_q       <= flags_l[2];
      vsync_q       <= flags_l[3];
      frame_start_q <= flags_l[4];
    end
  end

  assign fb_addr_o     = fb_addr_q;
  assign pixel_out_o   = pixel_q;
  assign visible_o     = visible_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch using reduced timing so several frames fit in a short run.
// Three instances: A (latency 1, green background), B (latency 3), C (full-screen image).
module tb_vga_pixel_fetch;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 8, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;  // 24
  localparam int VT = VV + VF + VS + VB;  // 13
  localparam int FRAME = HT * VT;         // 312

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  addr_a, addr_b, addr_c;
  logic [23:0] rdata_a, rdata_b, rdata_c;
  logic [23:0] px_a, px_b, px_c;
  logic        vis_a, vis_b, vis_c, hs_a, hs_b, hs_c, vs_a, vs_b, vs_c, fs_a, fs_b, fs_c;

  int checks = 0;
  int failures = 0;

  // Memory contents: never zero, so a leak during blanking is visible.
  function automatic logic [23:0] mem_data(input logic [7:0] a);
    return {8'hFF, a, ~a};
  endfunction

  vga_pixel_fetch #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(10), .IMG_H(5), .ADDR_W(8), .MEM_LATENCY(1), .BG_COLOR(24'h00FF00)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .fb_addr_o(addr_a), .fb_rdata_i(rdata_a),
    .pixel_out_o(px_a), .visible_o(vis_a), .hsync_o(hs_a), .vsync_o(vs_a),
    .frame_start_o(fs_a)
  );

  vga_pixel_fetch #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(10), .IMG_H(5), .ADDR_W(8), .MEM_LATENCY(3), .BG_COLOR(24'h123456)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .fb_addr_o(addr_b), .fb_rdata_i(rdata_b),
    .pixel_out_o(px_b), .visible_o(vis_b), .hsync_o(hs_b), .vsync_o(vs_b),
    .frame_start_o(fs_b)
  );

  vga_pixel_fetch #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(HV), .IMG_H(VV), .ADDR_W(8), .MEM_LATENCY(2), .BG_COLOR(24'hFF00FF)
  ) u_dut_c (
    .clk_i(clk), .rst_i(rst), .fb_addr_o(addr_c), .fb_rdata_i(rdata_c),
    .pixel_out_o(px_c), .visible_o(vis_c), .hsync_o(hs_c), .vsync_o(vs_c),
    .frame_start_o(fs_c)
  );

  // Synchronous-read memory models with 1, 3 and 2 cycles of latency.
  logic [23:0] mb1, mb2, mc1;
  always @(posedge clk) begin
    rdata_a <= mem_data(addr_a);
    mb1     <= mem_data(addr_b);
    mb2     <= mb1;
    rdata_b <= mb2;
    mc1     <= mem_data(addr_c);
    rdata_c <= mc1;
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // k = clock edges since reset release (0 = still in / just out of reset).
  task automatic check_one(input string nm, input int k, input int lat, input int iw,
                           input int ih, input logic [23:0] bg, input logic [23:0] px,
                           input logic vis, input logic hs, input logic vs, input logic fs,
                           input logic [7:0] addr);
    int s, h, v, ea;
    logic [23:0] e_px;
    logic e_vis, e_hs, e_vs, e_fs;
    e_px = '0; e_vis = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
    s = k - (lat + 2);
    if (s >= 0) begin
      h = s % HT;
      v = (s / HT) % VT;
      e_vis = (h < HV) && (v < VV);
      e_hs  = !((h >= HV + HF) && (h < HV + HF + HS));
      e_vs  = !((v >= VV + VF) && (v < VV + VF + VS));
      e_fs  = (h == 0) && (v == 0);
      if (e_vis) e_px = (h < iw && v < ih) ? mem_data(8'(v * iw + h)) : bg;
    end
    ea = 0;
    if (k > 0) begin
      h = (k - 1) % HT;
      v = ((k - 1) / HT) % VT;
      if (v < ih) ea = (h < iw) ? v * iw + h : v * iw + iw - 1;
      else ea = iw * ih - 1;
    end
    chk({nm, "_pixel"}, k, {8'h0, px}, {8'h0, e_px});
    chk({nm, "_visible"}, k, {31'h0, vis}, {31'h0, e_vis});
    chk({nm, "_hsync"}, k, {31'h0, hs}, {31'h0, e_hs});
    chk({nm, "_vsync"}, k, {31'h0, vs}, {31'h0, e_vs});
    chk({nm, "_frame_start"}, k, {31'h0, fs}, {31'h0, e_fs});
    chk({nm, "_fb_addr"}, k, {24'h0, addr}, 32'(ea));
  endtask

  task automatic check_all(input int k);
    check_one("a", k, 1, 10, 5, 24'h00FF00, px_a, vis_a, hs_a, vs_a, fs_a, addr_a);
    check_one("b", k, 3, 10, 5, 24'h123456, px_b, vis_b, hs_b, vs_b, fs_b, addr_b);
    check_one("c", k, 2, HV, VV, 24'hFF00FF, px_c, vis_c, hs_c, vs_c, fs_c, addr_c);
  endtask

  initial begin
    // Power-on reset: all outputs inactive.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all(0);
    rst = 1'b0;

    // Two full frames plus a few cycles of the third, every cycle checked.
    for (int k = 1; k <= 2 * FRAME + 10; k++) begin
      @(negedge clk);
      check_all(k);
    end

    // Asynchronous reset mid-line, sampled before any further clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Restart from (0,0): frame_start must appear exactly latency+2 edges later.
    for (int k = 1; k <= 2 * HT + 8; k++) begin
      @(negedge clk);
      check_all(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Upstream neighbour of the dithering stage in the VGA serial display path.
- Generates 640x480 VGA timing and reads the serial-loaded frame buffer through its synchronous read port.
- Presents a 24-bit pixel word {B[23:16], G[15:8], R[7:0]} with a `visible` flag and sync signals, all mutually aligned, ready for the dithering/output stage.
- Image region is IMG_W x IMG_H at the top-left of the screen. The rest of the visible area is filled with BG_COLOR.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- IMG_W, 320, frame-buffer image width (must be <= H_VISIBLE)
- IMG_H, 240, frame-buffer image height (must be <= V_VISIBLE)
- ADDR_W, 17, frame-buffer address width (2^ADDR_W >= IMG_W*IMG_H)
- MEM_LATENCY, 1, cycles from fb_addr valid to fb_rdata valid (1..3)
- BG_COLOR, 24'h000000, colour for visible pixels outside the image

Ports:
- clk, in, 1, pixel clock (25 MHz nominal)
- rst, in, 1, asynchronous active-high reset
- fb_addr, out, ADDR_W, frame-buffer read address (registered)
- fb_rdata, in, 24, frame-buffer read data, valid MEM_LATENCY cycles after fb_addr
- pixel_out, out, 24, aligned pixel word; feeds the dithering stage data_in
- visible, out, 1, high while pixel_out is in the 640x480 active area
- hsync, out, 1, horizontal sync, active-low
- vsync, out, 1, vertical sync, active-low
- frame_start, out, 1, one-cycle pulse aligned with output pixel (0,0)

Behaviour:
Timing counters and reset values:
- Definitions: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Counters: hc runs 0..H_TOTAL-1 and wraps to 0. vc increments when hc wraps and runs 0..V_TOTAL-1, wrapping to 0 at (H_TOTAL-1, V_TOTAL-1).
- Reset (async): hc=vc=0, fb_addr=0, pixel_out=0, visible=0, hsync=1, vsync=1, frame_start=0. All delay-line stages clear to the inactive values (sync=1, flags=0).

Stage-0 flags, combinational from hc/vc:
- vis0 = hc<H_VISIBLE && vc<V_VISIBLE
- img0 = hc<IMG_W && vc<IMG_H
- hs0 = !(H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC)
- vs0 = !(V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC)
- fs0 = (hc==0 && vc==0)

Address generation (no multiplier):
- Internal counter addr_cnt is cleared when the counters wrap to (0,0).
- addr_cnt increments by 1 on each cycle where img0 is 1.
- fb_addr register loads addr_cnt when img0=1. Otherwise it holds its value.
- Net effect: row-major addresses 0..IMG_W*IMG_H-1 per frame, with no gaps or duplicates. After the last image pixel, fb_addr stays at IMG_W*IMG_H-1 until the next frame.

Pipeline and latency:
- Counter state in cycle n maps to outputs in cycle n+L, where L = MEM_LATENCY+2:
  - 1 cycle for the fb_addr register
  - MEM_LATENCY cycles for the memory
  - 1 cycle for the output register
- vis0, img0, hs0, vs0 and fs0 each go through an L-stage shift register.
- Output register:
  - pixel_out = !vis_d ? 0 : (img_d ? fb_rdata : BG_COLOR)
  - visible = vis_d, hsync = hs_d, vsync = vs_d, frame_start = fs_d
- No output is combinational from inputs.

Boundary conditions:
- Reset released mid-frame: timing restarts at (0,0). The first valid frame_start is cycle L after the release edge. Outputs stay inactive during the first L cycles.
- IMG_W=H_VISIBLE and IMG_H=V_VISIBLE: BG_COLOR is never output.
- fb_rdata is ignored (pixel_out forced to 0) whenever the delayed visible flag is 0, including blanking and sync.

Test Plan:
- Reset check: assert rst mid-line -> same cycle (async) hsync=1, vsync=1, visible=0, pixel_out=0, fb_addr=0; after release, frame_start pulses exactly MEM_LATENCY+2 cycles later.
- Line timing, MEM_LATENCY=1: visible high for exactly 640 cycles per line, period 800; hsync low for 96 cycles starting 656 cycles after visible rises; vsync low for 2 lines (1600 cycles) starting 490 lines after frame_start; frame period 420000 cycles.
- Address sequence: model memory returns data=address -> pixel_out[16:0] on line 0 reads 0..319; line 1 starts at 320; last image pixel (319,239) reads 76799; no repeats or skips.
- Background: BG_COLOR=24'h00FF00 -> visible pixels at hc 320..639 or vc>=240 give 24'h00FF00; blanking gives 24'h000000 even with fb_rdata=24'hFFFFFF.
- Latency parameter: repeat the address test with MEM_LATENCY=3 (memory model delays 3) -> pixel_out at (0,0) still equals data for address 0, coincident with frame_start and visible rising.
- Frame wrap: run 2 frames -> fb_addr returns to 0 at frame start; second frame's pixel stream is identical to the first's.
